// File: rtl/sc_stoch_to_bin.sv
// Stochastic-to-binary converter: counts ones over a window of 2^WIDTH valid samples and
// presents the total (unipolar) or total minus N/2 (bipolar) through a valid/ready handshake.
module sc_stoch_to_bin #(
  parameter int WIDTH   = 8,
  parameter bit BIPOLAR = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           in_bit,
  input  logic           in_valid,
  output logic           busy,
  output logic [WIDTH:0] out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  // state | meaning
  // IDLE  | waiting for start; samples are dropped
  // COUNT | accumulating valid samples of the current window
  // HOLD  | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] SMP_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   HALF     = {2'b01, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_nxt;
  logic             clr;
  logic             take;
  logic             take_last;
  logic [WIDTH-1:0] smp_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH:0]   ones_final;
  logic [WIDTH:0]   result;

  assign take       = (state == COUNT) && in_valid;
  assign take_last  = take && (smp_cnt == SMP_LAST);
  assign ones_final = ones_cnt + {{WIDTH{1'b0}}, in_bit};
  // Bipolar result is the half-scaled value x*N/2, wrapping naturally into two's complement.
  assign result     = BIPOLAR ? (ones_final - HALF) : ones_final;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          clr       = 1'b1;
        end
      end
      COUNT: begin
        if (take_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_nxt = COUNT;
            clr       = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      smp_cnt  <= '0;
      ones_cnt <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        smp_cnt  <= '0;
        ones_cnt <= '0;
      end else if (take) begin
        smp_cnt  <= smp_cnt + 1'b1;
        ones_cnt <= ones_final;
      end
      if (take_last) out_data <= result;
    end
  end

  assign busy      = (state == COUNT);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_sc_stoch_to_bin.sv
// Bench for sc_stoch_to_bin: unipolar and bipolar instances share one random stimulus stream
// and are compared every cycle against a window-queue model, plus literal result checks.
module tb_sc_stoch_to_bin;
  localparam int W = 4;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst, start, in_bit, in_valid, out_ready;
  logic busy_u, valid_u, busy_b, valid_b;
  logic [W:0] data_u, data_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: phase 0 = idle, 1 = collecting window, 2 = result waiting for consumer
  int m_phase = 0;
  bit m_win[$];
  logic [W:0] m_out_u = '0;
  logic [W:0] m_out_b = '0;

  always #5 clk = ~clk;

  sc_stoch_to_bin #(.WIDTH(W), .BIPOLAR(1'b0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .in_bit(in_bit), .in_valid(in_valid),
    .busy(busy_u), .out_data(data_u), .out_valid(valid_u), .out_ready(out_ready)
  );

  sc_stoch_to_bin #(.WIDTH(W), .BIPOLAR(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_bit(in_bit), .in_valid(in_valid),
    .busy(busy_b), .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_win.delete();
      m_out_u = '0;
      m_out_b = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_win.delete();
      end
    end else if (m_phase == 1) begin
      if (in_valid) begin
        m_win.push_back(in_bit);
        if (m_win.size() == N) begin
          int ones;
          ones = 0;
          foreach (m_win[i]) ones += int'(m_win[i]);
          m_out_u = (W+1)'(ones);
          m_out_b = (W+1)'(ones - N / 2);
          m_phase = 2;
        end
      end
    end else begin
      if (out_ready) begin
        m_phase = start ? 1 : 0;
        m_win.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_u", busy_u, m_phase == 1);
      check("busy_b", busy_b, m_phase == 1);
      check("valid_u", valid_u, m_phase == 2);
      check("valid_b", valid_b, m_phase == 2);
      check("data_u", data_u, m_out_u);
      check("data_b", data_b, m_out_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hand-computed results: mode 0 all zeros, 1 all ones, 2 alternating starting with 1
  task automatic check_lit(input int mode);
    logic [W:0] lit_u [3] = '{5'd0, 5'd16, 5'd8};
    logic [W:0] lit_b [3] = '{5'b11000, 5'b01000, 5'b00000};
    if (mode < 3) begin
      check("lit_u", data_u, lit_u[mode]);
      check("lit_b", data_b, lit_b[mode]);
    end
  endtask

  task automatic run_window(input int mode, input bit do_start, input int gap_pct, input bit mid_start);
    int got;
    int guard;
    got = 0;
    guard = 0;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (got < N && guard < 2000) begin
      in_valid = (int'($urandom_range(99)) >= gap_pct);
      case (mode)
        0:       in_bit = 1'b0;
        1:       in_bit = 1'b1;
        2:       in_bit = (got[0] == 1'b0);
        default: in_bit = 1'($urandom_range(1));
      endcase
      if (!in_valid) in_bit = 1'($urandom_range(1));
      start = mid_start && ($urandom_range(4) == 0);
      if (in_valid) got++;
      guard++;
      tick();
    end
    if (guard >= 2000) check("window_bound", 32'(got), 32'(N));
    in_valid = 1'b0;
    start = 1'b0;
    check("latency_valid", valid_u, 1'b1);
    check("latency_busy", busy_u, 1'b0);
  endtask

  task automatic hold_and_ack(input int hold_cycles, input bit b2b);
    repeat (hold_cycles) begin
      out_ready = 1'b0;
      start = 1'($urandom_range(1));
      in_valid = 1'($urandom_range(1));
      in_bit = 1'($urandom_range(1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = b2b;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("ack_valid", valid_u, 1'b0);
    check("ack_busy", busy_u, b2b);
  endtask

  initial begin
    bit pending;
    rst = 1'b1;
    start = 1'b0;
    in_bit = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", busy_u, 1'b0);
    check("rst_valid", valid_u, 1'b0);
    check("rst_data_u", data_u, 5'd0);
    check("rst_data_b", data_b, 5'd0);

    // idle samples must be ignored
    repeat (4) begin
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
    end
    in_valid = 1'b0;

    // all ones with consumer always ready: one-cycle out_valid pulse
    out_ready = 1'b1;
    run_window(1, 1'b1, 0, 1'b0);
    check_lit(1);
    tick();
    check("ready_pulse", valid_u, 1'b0);
    out_ready = 1'b0;

    run_window(0, 1'b1, 0, 1'b0);
    check_lit(0);
    hold_and_ack(0, 1'b0);
    run_window(2, 1'b1, 0, 1'b0);
    check_lit(2);
    hold_and_ack(2, 1'b0);

    // ones with gaps and mid-window starts, long hold, back-to-back restart
    run_window(1, 1'b1, 60, 1'b1);
    check_lit(1);
    hold_and_ack(10, 1'b1);
    run_window(2, 1'b0, 30, 1'b1);
    check_lit(2);
    hold_and_ack(1, 1'b0);

    // reset mid-window after 7 valid samples, then a clean zero window
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    repeat (7) tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy_u, 1'b0);
    check("midrst_valid", valid_u, 1'b0);
    check("midrst_data_b", data_b, 5'd0);
    run_window(0, 1'b1, 20, 1'b0);
    check_lit(0);
    hold_and_ack(0, 1'b0);

    // reset while holding a result
    run_window(1, 1'b1, 0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("holdrst_valid", valid_u, 1'b0);
    check("holdrst_data_u", data_u, 5'd0);
    repeat (3) tick();

    pending = 1'b0;
    for (int k = 0; k < 20; k++) begin
      int mode;
      bit b2b;
      mode = int'($urandom_range(3));
      b2b = (k < 19) ? 1'($urandom_range(1)) : 1'b0;
      run_window(mode, !pending, int'($urandom_range(60)), 1'($urandom_range(1)));
      check_lit(mode);
      hold_and_ack(int'($urandom_range(5)), b2b);
      pending = b2b;
      if (!b2b) repeat (int'($urandom_range(3))) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
